approx_add_sched: RTL and testbench

- Sequencer and arbiter that shares one combinational 8-bit approximate adder between two requesters.
- The adder itself is external and is built from the 2-bit approximate segments. This block only handles the sequencing around it:
  - accepts operand pairs over a valid/ready handshake;
  - arbitrates round-robin between the two requesters;
  - drives the shared adder and registers its sum/carry;
  - presents the tagged result on a valid/ready output.

---
 rtl/approx_add_sched.sv | 138 +++++++++++++
 tb/tb_approx_add_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_sched.sv
// approx_add_sched: round-robin sequencer that shares one external
// combinational adder between two requesters. Each accepted operand pair
// goes IDLE -> EXEC -> DONE, and the tagged {carry, sum} result is held
// until the consumer takes it.
module approx_add_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_src,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             src_q, src_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH:0]   res_sum_q, res_sum_d;
  logic             res_src_q, res_src_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             grant;

  // Round-robin pick: a tie goes to the requester that did not win last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Next-state, operand capture, result capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    res_sum_d    = res_sum_q;
    res_src_d    = res_src_q;
    res_valid_d  = res_valid_q;
    op_count_d   = op_count_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready   = ~grant;
          req1_ready   = grant;
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          src_d        = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // The external adder sees a_q/b_q for this whole cycle.
        res_sum_d   = {add_cout, add_sum};
        res_src_d   = src_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      res_sum_q    <= '0;
      res_src_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      res_sum_q    <= res_sum_d;
      res_src_q    <= res_src_d;
      res_valid_q  <= res_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = 1'b0;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_src   = res_src_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_approx_add_sched.sv
// tb_approx_add_sched: exercises approx_add_sched against an exact-adder
// reference, with a small arbitration/counter model kept in the bench.
module tb_approx_add_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [8:0]  res_sum;
  logic        res_src, busy;
  logic [15:0] op_count;

  int          vectors = 0;
  int          miscompares = 0;

  // Reference state: who won last, how many results have completed.
  logic        m_last;
  logic [15:0] m_count;

  approx_add_sched #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_src(res_src),
    .busy(busy), .op_count(op_count)
  );

  // Exact adder standing in for the external approximate one.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
    vectors++; if (res_sum !== 9'h000) begin miscompares++; $display("FAIL reset_res_sum got %h want 000", res_sum); end
    vectors++; if (res_src !== 1'b0) begin miscompares++; $display("FAIL reset_res_src got %0b want 0", res_src); end
    vectors++; if (op_count !== 16'h0000) begin miscompares++; $display("FAIL reset_op_count got %h want 0000", op_count); end
    vectors++; if ({add_a, add_b} !== 16'h0000) begin miscompares++; $display("FAIL reset_add_ab got %h/%h want 00/00", add_a, add_b); end
    vectors++; if ({busy, add_cin} !== 2'b00) begin miscompares++; $display("FAIL reset_busy_cin got %0b%0b want 00", busy, add_cin); end
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
    m_count = 16'h0000;
    $display("txn reset done");
  endtask

  // One request through to completion. Entry and exit at a negedge in IDLE.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1,
                         input int hold, input string name);
    logic       g;
    logic [7:0] ea, eb;
    logic [8:0] esum;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    res_ready = 1'b0;
    #1;
    if (!v0 && !v1) begin
      vectors++; if ({req0_ready, req1_ready, busy} !== 3'b000) begin miscompares++; $display("FAIL %s idle_ready got r0=%0b r1=%0b busy=%0b want 000", name, req0_ready, req1_ready, busy); end
      @(negedge clk);
      $display("txn %s: no request", name);
      return;
    end
    g = (v0 && v1) ? ~m_last : v1;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    esum = {1'b0, ea} + {1'b0, eb};
    vectors++; if ({req0_ready, req1_ready} !== {~g, g}) begin miscompares++; $display("FAIL %s grant got r0=%0b r1=%0b want r0=%0b r1=%0b", name, req0_ready, req1_ready, ~g, g); end
    m_last = g;
    // EXEC: offer new pairs anyway; none may be accepted.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'($urandom); req1_a = 8'($urandom);
    #1;
    vectors++; if ({req0_ready, req1_ready, res_valid, busy} !== 4'b0001) begin miscompares++; $display("FAIL %s exec got r0=%0b r1=%0b vld=%0b busy=%0b want 0001", name, req0_ready, req1_ready, res_valid, busy); end
    vectors++; if ({add_a, add_b} !== {ea, eb}) begin miscompares++; $display("FAIL %s operands got %h/%h want %h/%h", name, add_a, add_b, ea, eb); end
    // DONE (handshake + 2): result must be present.
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    vectors++; if ({res_valid, res_src, res_sum} !== {1'b1, g, esum}) begin miscompares++; $display("FAIL %s result got vld=%0b src=%0b sum=%h want 1 %0b %h", name, res_valid, res_src, res_sum, g, esum); end
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_b = 8'($urandom); req1_b = 8'($urandom);
      #1;
      vectors++; if ({req0_ready, req1_ready, busy, res_valid, res_src, res_sum} !== {4'b0011, g, esum}) begin miscompares++; $display("FAIL %s hold%0d got r0=%0b r1=%0b busy=%0b vld=%0b src=%0b sum=%h", name, i, req0_ready, req1_ready, busy, res_valid, res_src, res_sum); end
      vectors++; if ({add_a, add_b} !== {ea, eb}) begin miscompares++; $display("FAIL %s hold_operands got %h/%h want %h/%h", name, add_a, add_b, ea, eb); end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_count = m_count + 16'd1;
    #1;
    vectors++; if ({res_valid, busy, op_count} !== {2'b00, m_count}) begin miscompares++; $display("FAIL %s complete got vld=%0b busy=%0b cnt=%h want 0 0 %h", name, res_valid, busy, op_count, m_count); end
    @(negedge clk);
    $display("txn %s: src=%0b %h+%h=%h hold=%0d count=%h", name, g, ea, eb, esum, hold, m_count);
  endtask

  task automatic test_basic();
    run_txn(1'b1, 1'b0, 8'h3C, 8'h0F, 8'h00, 8'h00, 0, "basic_req0");
  endtask

  task automatic test_stall();
    run_txn(1'b0, 1'b1, 8'hA5, 8'h7E, 8'hC3, 8'h51, 5, "stall_req1");
  endtask

  // Both requesters valid every cycle, consumer always ready.
  task automatic test_back_to_back();
    logic g;
    g = 1'b0;
    req0_a = 8'hFF; req0_b = 8'h01; req1_a = 8'hFF; req1_b = 8'h01;
    res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      if (c % 3 == 0) begin
        g = ~m_last;
        m_last = g;
        vectors++; if ({req0_ready, req1_ready} !== {~g, g}) begin miscompares++; $display("FAIL b2b_grant c=%0d got r0=%0b r1=%0b want %0b %0b", c, req0_ready, req1_ready, ~g, g); end
      end else begin
        vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL b2b_noready c=%0d got r0=%0b r1=%0b want 00", c, req0_ready, req1_ready); end
      end
      if (c % 3 == 2) begin
        vectors++; if ({res_valid, res_src, res_sum} !== {1'b1, g, 9'h100}) begin miscompares++; $display("FAIL b2b_result c=%0d got vld=%0b src=%0b sum=%h want 1 %0b 100", c, res_valid, res_src, res_sum, g); end
        m_count = m_count + 16'd1;
        $display("txn b2b: src=%0b sum=100 count=%h", g, m_count);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    #1;
    vectors++; if ({busy, op_count} !== {1'b0, m_count}) begin miscompares++; $display("FAIL b2b_end got busy=%0b cnt=%h want 0 %h", busy, op_count, m_count); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_exec();
    req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL rexec_grant got %0b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #2;
    vectors++; if ({busy, add_a} !== {1'b1, 8'hAA}) begin miscompares++; $display("FAIL rexec_pre got busy=%0b a=%h want 1 aa", busy, add_a); end
    rst = 1'b1;
    #1;
    vectors++; if ({res_valid, busy, op_count, add_a, add_b} !== 34'h0) begin miscompares++; $display("FAIL rexec_async got vld=%0b busy=%0b cnt=%h a=%h b=%h want all 0", res_valid, busy, op_count, add_a, add_b); end
    @(negedge clk);
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rexec_noresult got %0b want 0", res_valid); end
    rst = 1'b0;
    m_last = 1'b1;
    m_count = 16'h0000;
    $display("txn reset_in_exec: operation dropped");
    run_txn(1'b1, 1'b1, 8'h12, 8'h34, 8'h56, 8'h78, 0, "post_reset_tie");
    run_txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h80, 0, "post_reset_req1");
  endtask

  task automatic test_wrap();
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    #1;
    vectors++; if (op_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preset got %h want ffff", op_count); end
    m_count = 16'hFFFF;
    @(negedge clk);
    run_txn(1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 0, "wrap");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_txn(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_in_exec();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
